// File: rtl/uc_pkg.sv
// Shared opcode-class constants and FSM state type for the unidad_control slice.
package uc_pkg;

  // opcode[5] selects the ALU class; the remaining classes decode opcode[5:2]
  localparam logic       OPC_ALU  = 1'b0;
  localparam logic [3:0] OPC_LI   = 4'b1000;
  localparam logic [3:0] OPC_JMP  = 4'b1001;
  localparam logic [3:0] OPC_JZ   = 4'b1010;
  localparam logic [3:0] OPC_JNZ  = 4'b1011;
  localparam logic [3:0] OPC_JAL  = 4'b1100;
  localparam logic [3:0] OPC_RET  = 4'b1101;
  localparam logic [3:0] OPC_NOP  = 4'b1110;
  localparam logic [3:0] OPC_HALT = 4'b1111;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO with a saturating pointer; push when full and pop when
// empty are ignored here and flagged as errors by the controller.
module ret_stack
  import uc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] SP_FULL = PW'(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] sp;
  logic [IW-1:0] top_idx;

  assign full    = (sp == SP_FULL);
  assign empty   = (sp == '0);
  assign top_idx = IW'(sp - PW'(1));
  assign top     = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[sp[IW-1:0]] <= din;
      sp              <= sp + PW'(1);
    end else if (pop && !empty) begin
      sp <= sp - PW'(1);
    end
  end

endmodule

// File: rtl/unidad_control.sv
// Instruction-class decoder and RUN/HALT/ERR sequencer for the small CPU.
// Define UC_STACK_EN to build the JAL/RET return stack; otherwise JAL/RET act as NOP.
//   state   | meaning
//   ST_RUN  | normal execution, PC advances every cycle
//   ST_HALT | HALT executed, PC and register writes frozen until reset
//   ST_ERR  | return-stack overflow/underflow, frozen until reset
module unidad_control
  import uc_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    opcode,
  input  logic          z,
  input  logic [AW-1:0] pc_next,
  output logic          s_inc,
  output logic          s_inm,
  output logic          we3,
  output logic          wez,
  output logic [2:0]    op_alu,
  output logic          s_ret,
  output logic [AW-1:0] ret_addr,
  output logic          pc_we,
  output logic          halted,
  output logic          stack_err
);

  state_t     state;
  logic [3:0] cls;
  logic       run;
  logic       is_jal;
  logic       is_ret;
  logic       ovf;
  logic       unf;
  logic       unused_op;

  assign cls       = opcode[5:2];
  assign run       = (state == ST_RUN);
  assign halted    = (state == ST_HALT);
  assign unused_op = ^opcode[1:0];

`ifdef UC_STACK_EN
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [AW-1:0] top;

  assign is_jal    = (cls == OPC_JAL);
  assign is_ret    = (cls == OPC_RET);
  assign ovf       = run & is_jal & full;
  assign unf       = run & is_ret & empty;
  assign push      = run & is_jal & ~full;
  assign pop       = run & is_ret & ~empty;
  assign ret_addr  = top;
  assign stack_err = (state == ST_ERR);

  ret_stack #(
    .DEPTH(STACK_DEPTH),
    .AW   (AW)
  ) u_ret_stack (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (pc_next),
    .top  (top),
    .full (full),
    .empty(empty)
  );
`else
  logic unused_pc;

  assign is_jal    = 1'b0;
  assign is_ret    = 1'b0;
  assign ovf       = 1'b0;
  assign unf       = 1'b0;
  assign ret_addr  = '0;
  assign stack_err = 1'b0;
  assign unused_pc = ^pc_next;
`endif

  always_comb begin
    s_inc  = 1'b1;
    s_inm  = 1'b0;
    we3    = 1'b0;
    wez    = 1'b0;
    op_alu = 3'b000;
    s_ret  = 1'b0;
    pc_we  = run;
    if (opcode[5] == OPC_ALU) begin
      op_alu = opcode[4:2];
      we3    = 1'b1;
      wez    = 1'b1;
    end else begin
      case (cls)
        OPC_LI:   begin s_inm = 1'b1; we3 = 1'b1; end
        OPC_JMP:  s_inc = 1'b0;
        OPC_JZ:   s_inc = ~z;
        OPC_JNZ:  s_inc = z;
        OPC_HALT: pc_we = 1'b0;
        default:  ;
      endcase
    end
    if (is_jal) s_inc = 1'b0;
    if (is_ret) s_ret = 1'b1;
    // a faulting JAL/RET must not move the PC so the offending address is kept
    if (ovf || unf) begin
      pc_we = 1'b0;
      s_ret = 1'b0;
    end
    if (!run) begin
      pc_we = 1'b0;
      we3   = 1'b0;
      wez   = 1'b0;
      s_ret = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (cls == OPC_HALT)  state <= ST_HALT;
          else if (ovf || unf)  state <= ST_ERR;
        end
        default: ;
      endcase
    end
  end

endmodule
